// File: rtl/proc_hier_top_pkg.sv
// Shared widths, opcodes, pipeline records and the instruction ROM image
// for the processor hierarchy and its statistics block.
// Imported by proc, proc_stats and proc_hier_top.
package proc_hier_top_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int CNT_W_DEF  = 32;
  localparam int PC_W       = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LLI  = 4'h1,  // rd = imm8
    OP_SLBI = 4'h2,  // rd = {rd[7:0], imm8}
    OP_ADD  = 4'h3,  // rd = rs + rt
    OP_ST   = 4'h4,  // mem[rs] = rt
    OP_LD   = 4'h5,  // rd = mem[rs]
    OP_HALT = 4'hF
  } opcode_e;

  // One cycle's worth of events feeding the statistics counters.
  typedef struct packed {
    logic halt;
    logic retire;
    logic icacheReq;
    logic icacheHit;
    logic dcacheReq;
    logic dcacheHit;
  } statsStrobe_t;

  typedef struct packed {
    opcode_e               op;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     aVal;
    logic [DATA_W-1:0]     bVal;
    logic [7:0]            imm;
  } idEx_t;

  typedef struct packed {
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] rd;
    logic                  memEn;
    logic                  memWrite;
    logic                  dump;
    logic [DATA_W-1:0]     aluResult;
    logic [DATA_W-1:0]     rtValue;
  } exMem_t;

  typedef struct packed {
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
    logic                  dump;
  } memWb_t;

  // Boot program. There is no hazard detection in the core, so dependent
  // instructions sit three slots apart (two NOPs) to pick up the WB bypass.
  function automatic logic [DATA_W-1:0] romWord(input logic [PC_W-1:0] pc);
    logic [DATA_W-1:0] w;
    w = '0;
    case (pc)
      4'd0:  w = {OP_LLI,  3'd3, 1'b0, 8'h05};        // r3 = 0x0005
      4'd1:  w = {OP_LLI,  3'd1, 1'b0, 8'h10};        // r1 = 0x0010
      4'd2:  w = {OP_LLI,  3'd2, 1'b0, 8'h12};        // r2 = 0x0012
      4'd5:  w = {OP_SLBI, 3'd2, 1'b0, 8'h34};        // r2 = 0x1234
      4'd8:  w = {OP_ST,   3'd0, 3'd1, 3'd2, 3'd0};   // mem[r1] = r2
      4'd9:  w = {OP_LD,   3'd4, 3'd1, 3'd0, 3'd0};   // r4 = mem[r1]
      4'd12: w = {OP_ADD,  3'd5, 3'd3, 3'd4, 3'd0};   // r5 = r3 + r4
      4'd13: w = {OP_HALT, 12'h000};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/proc.sv
// Minimal 5-stage in-order core (IF/ID/EX/MEM/WB) running a ROM program.
// No stalls: fetch stops after HALT and the pipeline then drains NOPs.
// WB->ID register bypass; all pipeline registers clear on synchronous rst.
module proc
  import proc_hier_top_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  output logic                  wbRegWrite,
  output logic [REG_ADDR_W-1:0] wbRd,
  output logic [DATA_W-1:0]     wbData,
  output logic                  wbDump,
  output logic                  exMemEn,
  output logic                  exMemWrite,
  output logic [DATA_W-1:0]     exAluResult,
  output logic [DATA_W-1:0]     exRtValue,
  output logic [DATA_W-1:0]     memReadData
);

  logic [PC_W-1:0]       pc;
  logic                  fetchDone;
  logic [DATA_W-1:0]     fetchInst;
  logic [DATA_W-1:0]     ifIdInst;
  idEx_t                 idEx, idNext;
  exMem_t                exMem, exNext;
  memWb_t                memWb, wbNext;
  logic [DATA_W-1:0]     rf   [8];
  logic [DATA_W-1:0]     dmem [16];
  opcode_e               idOp;
  logic [REG_ADDR_W-1:0] addrA, addrB;

  assign fetchInst = romWord(pc);

  // Fetch: advance PC until HALT has been fetched, then feed NOPs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      fetchDone <= 1'b0;
      ifIdInst  <= '0;
    end else if (!fetchDone) begin
      ifIdInst <= fetchInst;
      pc       <= pc + 4'd1;
      if (fetchInst[15:12] == OP_HALT) fetchDone <= 1'b1;
    end else begin
      ifIdInst <= '0;
    end
  end

  // Decode and register read, bypassing the value being written back.
  always_comb begin
    idNext = '0;
    idOp   = opcode_e'(ifIdInst[15:12]);
    addrA  = (idOp == OP_SLBI) ? ifIdInst[11:9] : ifIdInst[8:6];
    addrB  = ifIdInst[5:3];
    idNext.op   = idOp;
    idNext.rd   = ifIdInst[11:9];
    idNext.imm  = ifIdInst[7:0];
    idNext.aVal = (memWb.regWrite && memWb.rd == addrA) ? memWb.data : rf[addrA];
    idNext.bVal = (memWb.regWrite && memWb.rd == addrB) ? memWb.data : rf[addrB];
  end

  // Execute: ALU result doubles as the data memory address.
  always_comb begin
    exNext         = '0;
    exNext.rd      = idEx.rd;
    exNext.rtValue = idEx.bVal;
    case (idEx.op)
      OP_LLI:  begin exNext.regWrite = 1'b1; exNext.aluResult = {8'h00, idEx.imm}; end
      OP_SLBI: begin exNext.regWrite = 1'b1; exNext.aluResult = {idEx.aVal[7:0], idEx.imm}; end
      OP_ADD:  begin exNext.regWrite = 1'b1; exNext.aluResult = idEx.aVal + idEx.bVal; end
      OP_ST:   begin exNext.memEn = 1'b1; exNext.memWrite = 1'b1; exNext.aluResult = idEx.aVal; end
      OP_LD:   begin exNext.regWrite = 1'b1; exNext.memEn = 1'b1; exNext.aluResult = idEx.aVal; end
      OP_HALT: exNext.dump = 1'b1;
      default: exNext = exNext;
    endcase
  end

  // Memory stage: asynchronous read, so a load right after a store sees it.
  assign memReadData = dmem[exMem.aluResult[3:0]];

  // Writeback selection between load data and ALU result.
  always_comb begin
    wbNext          = '0;
    wbNext.regWrite = exMem.regWrite;
    wbNext.rd       = exMem.rd;
    wbNext.dump     = exMem.dump;
    wbNext.data     = (exMem.memEn && !exMem.memWrite) ? memReadData : exMem.aluResult;
  end

  // Pipeline registers ID/EX, EX/MEM, MEM/WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else begin
      idEx  <= idNext;
      exMem <= exNext;
      memWb <= wbNext;
    end
  end

  // Architectural storage: register file and data memory (not reset).
  always_ff @(posedge clk) begin
    if (!rst && memWb.regWrite) rf[memWb.rd] <= memWb.data;
    if (!rst && exMem.memEn && exMem.memWrite) dmem[exMem.aluResult[3:0]] <= exMem.rtValue;
  end

  assign wbRegWrite  = memWb.regWrite;
  assign wbRd        = memWb.rd;
  assign wbData      = memWb.data;
  assign wbDump      = memWb.dump;
  assign exMemEn     = exMem.memEn;
  assign exMemWrite  = exMem.memWrite;
  assign exAluResult = exMem.aluResult;
  assign exRtValue   = exMem.rtValue;

endmodule

// File: rtl/proc_stats.sv
// Run statistics: cycle/instruction counters and cache counters (CACHE_STATS_EN).
// Counts every non-halted cycle including the halt cycle; sticky halted freezes all.
// Synchronous active-high rst clears counters and the halted flag; counters wrap.
module proc_stats
  import proc_hier_top_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             retire,
  input  logic             icacheReq,
  input  logic             icacheHit,
  input  logic             dcacheReq,
  input  logic             dcacheHit,
  output logic [CNT_W-1:0] cycleCount,
  output logic [CNT_W-1:0] instCount,
  output logic [CNT_W-1:0] icacheReqCount,
  output logic [CNT_W-1:0] icacheHitCount,
  output logic [CNT_W-1:0] dcacheReqCount,
  output logic [CNT_W-1:0] dcacheHitCount
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  statsStrobe_t strobe;
  logic         halted;

  assign strobe = {halt, retire, icacheReq, icacheHit, dcacheReq, dcacheHit};

  // Core counters plus the sticky halted flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted     <= 1'b0;
      cycleCount <= '0;
      instCount  <= '0;
    end else if (!halted) begin
      cycleCount <= cycleCount + ONE;
      if (strobe.retire) instCount <= instCount + ONE;
      if (strobe.halt)   halted    <= 1'b1;
    end
  end

`ifdef CACHE_STATS_EN
  // Cache counters, gated by the same halted flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      icacheReqCount <= '0;
      icacheHitCount <= '0;
      dcacheReqCount <= '0;
      dcacheHitCount <= '0;
    end else if (!halted) begin
      if (strobe.icacheReq) icacheReqCount <= icacheReqCount + ONE;
      if (strobe.icacheHit) icacheHitCount <= icacheHitCount + ONE;
      if (strobe.dcacheReq) dcacheReqCount <= dcacheReqCount + ONE;
      if (strobe.dcacheHit) dcacheHitCount <= dcacheHitCount + ONE;
    end
  end
`else
  logic unusedCacheStrobes;
  assign unusedCacheStrobes = ^{strobe.icacheReq, strobe.icacheHit,
                                strobe.dcacheReq, strobe.dcacheHit};
  assign icacheReqCount = '0;
  assign icacheHitCount = '0;
  assign dcacheReqCount = '0;
  assign dcacheHitCount = '0;
`endif

endmodule

// File: rtl/proc_hier_top.sv
// Processor hierarchy: core + stats, flat trace of WB/MEM activity and halt.
// Trace outputs are combinational from pipeline registers (0 added latency).
// No backpressure; optional cache counters via CACHE_STATS_EN.
module proc_hier_top
  import proc_hier_top_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0]     write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_data_in,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic                  halt,
  output logic                  icache_req,
  output logic                  icache_hit,
  output logic                  dcache_req,
  output logic                  dcache_hit,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      inst_count,
  output logic [CNT_W-1:0]      icache_req_count,
  output logic [CNT_W-1:0]      icache_hit_count,
  output logic [CNT_W-1:0]      dcache_req_count,
  output logic [CNT_W-1:0]      dcache_hit_count
);

  logic dmemEn, dmemWrite;

  proc core (
    .clk         (clk),
    .rst         (rst),
    .wbRegWrite  (reg_write),
    .wbRd        (write_register),
    .wbData      (write_data),
    .wbDump      (halt),
    .exMemEn     (dmemEn),
    .exMemWrite  (dmemWrite),
    .exAluResult (mem_address),
    .exRtValue   (mem_data_in),
    .memReadData (mem_data_out)
  );

  // Split the EX/MEM enable into mutually exclusive load/store strobes.
  assign mem_read  = dmemEn & ~dmemWrite;
  assign mem_write = dmemEn & dmemWrite;

  // No caches in this hierarchy: every access is a request that misses.
  assign icache_req = 1'b1;
  assign dcache_req = 1'b1;
  assign icache_hit = 1'b0;
  assign dcache_hit = 1'b0;

  proc_stats #(.CNT_W(CNT_W)) stats (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .retire         (halt | reg_write | mem_write),
    .icacheReq      (icache_req),
    .icacheHit      (icache_hit),
    .dcacheReq      (dcache_req),
    .dcacheHit      (dcache_hit),
    .cycleCount     (cycle_count),
    .instCount      (inst_count),
    .icacheReqCount (icache_req_count),
    .icacheHitCount (icache_hit_count),
    .dcacheReqCount (dcache_req_count),
    .dcacheHitCount (dcache_hit_count)
  );

endmodule

// File: tb/tb_proc_hier_top.sv
// Bench for proc_hier_top: random reset lengths, random aborts and post-halt
// runs; expected trace events come from an architectural model of the program
// and are checked by a monitor against a queue, counters every cycle.
module tb_proc_hier_top;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_write, mem_read, mem_write, halt;
  logic [2:0]    write_register;
  logic [15:0]   write_data, mem_address, mem_data_in, mem_data_out;
  logic          icache_req, icache_hit, dcache_req, dcache_hit;
  logic [CW-1:0] cycle_count, inst_count;
  logic [CW-1:0] icache_req_count, icache_hit_count, dcache_req_count, dcache_hit_count;

  proc_hier_top #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .halt(halt),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .cycle_count(cycle_count), .inst_count(inst_count),
    .icache_req_count(icache_req_count), .icache_hit_count(icache_hit_count),
    .dcache_req_count(dcache_req_count), .dcache_hit_count(dcache_hit_count)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NOP, K_LLI, K_SLBI, K_ADD, K_ST, K_LD, K_HALT} kind_e;
  typedef struct {kind_e k; int rd; int rs; int rt; int imm;} instr_t;
  typedef struct {
    int cyc; bit rw; int wreg; int wdata; bit mr; bit mw; int addr; int din; int dout; bit hlt;
  } ev_t;

  instr_t prog[$];
  ev_t    slots[int];
  ev_t    runEvents[$];
  ev_t    expQ[$];
  int     haltCyc = 0;
  int     compared = 0;
  int     mismatched = 0;
  int     curCycle = 0;
  bit     started = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, curCycle);
    end
  endtask

  function automatic void addInstr(kind_e k, int rd, int rs, int rt, int imm);
    instr_t t;
    t.k = k; t.rd = rd; t.rs = rs; t.rt = rt; t.imm = imm;
    prog.push_back(t);
  endfunction

  function automatic ev_t getSlot(int c);
    ev_t e;
    if (slots.exists(c)) e = slots[c];
    else begin
      e = '{c, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0};
    end
    return e;
  endfunction

  // Architectural execution; an instruction in program slot i reaches the
  // memory stage in cycle i+4 and writeback in cycle i+5 after reset release.
  function automatic void buildModel();
    int  regs[8];
    int  mem[int];
    ev_t e;
    int  a, v;
    foreach (regs[r]) regs[r] = 0;
    foreach (prog[i]) begin
      case (prog[i].k)
        K_LLI, K_SLBI, K_ADD: begin
          if (prog[i].k == K_LLI) regs[prog[i].rd] = prog[i].imm;
          else if (prog[i].k == K_SLBI)
            regs[prog[i].rd] = ((regs[prog[i].rd] & 'hff) << 8) | prog[i].imm;
          else regs[prog[i].rd] = (regs[prog[i].rs] + regs[prog[i].rt]) & 'hffff;
          e = getSlot(i + 5); e.rw = 1; e.wreg = prog[i].rd; e.wdata = regs[prog[i].rd];
          slots[i + 5] = e;
        end
        K_ST: begin
          a = regs[prog[i].rs]; mem[a] = regs[prog[i].rt];
          e = getSlot(i + 4); e.mw = 1; e.addr = a; e.din = regs[prog[i].rt];
          slots[i + 4] = e;
        end
        K_LD: begin
          a = regs[prog[i].rs]; v = mem.exists(a) ? mem[a] : 0;
          e = getSlot(i + 4); e.mr = 1; e.addr = a; e.dout = v;
          slots[i + 4] = e;
          regs[prog[i].rd] = v;
          e = getSlot(i + 5); e.rw = 1; e.wreg = prog[i].rd; e.wdata = v;
          slots[i + 5] = e;
        end
        K_HALT: begin
          e = getSlot(i + 5); e.hlt = 1; slots[i + 5] = e;
          haltCyc = i + 5;
        end
        default: ;
      endcase
    end
    foreach (slots[c]) runEvents.push_back(slots[c]);
  endfunction

  // Instructions retired in cycles 1..n (one per cycle at most).
  function automatic int instUpTo(int n);
    int cnt = 0;
    foreach (runEvents[j])
      if (runEvents[j].cyc <= n && (runEvents[j].rw || runEvents[j].mw || runEvents[j].hlt)) cnt++;
    return cnt;
  endfunction

  // Cycle index of the current clock period: 1 for the period after a reset edge.
  always @(posedge clk) begin
    if (rst) begin
      curCycle = 1;
      started  = 1'b1;
    end else begin
      curCycle = curCycle + 1;
    end
  end

  // Monitor: counters and strobes every cycle, trace events against the queue.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  ec, expCache;
    if (started) begin
      ec = (curCycle - 1 < haltCyc) ? curCycle - 1 : haltCyc;
`ifdef CACHE_STATS_EN
      expCache = ec;
`else
      expCache = 0;
`endif
      check("cycle_count", cycle_count, ec);
      check("inst_count", inst_count, instUpTo(ec));
      check("icache_req_count", icache_req_count, expCache);
      check("dcache_req_count", dcache_req_count, expCache);
      check("icache_hit_count", icache_hit_count, 0);
      check("dcache_hit_count", dcache_hit_count, 0);
      check("cache_strobes", {icache_req, icache_hit, dcache_req, dcache_hit}, 4'b1010);
      check("rd_wr_exclusive", mem_read & mem_write, 0);

      while (expQ.size() > 0 && expQ[0].cyc < curCycle) begin
        check("trace_missing_event_cycle", curCycle, expQ[0].cyc);
        void'(expQ.pop_front());
      end
      if (reg_write || mem_read || mem_write || halt) begin
        if (expQ.size() == 0 || expQ[0].cyc != curCycle) begin
          check("unexpected_trace_cycle", curCycle, (expQ.size() > 0) ? expQ[0].cyc : -1);
        end else begin
          e = expQ.pop_front();
          check("reg_write", reg_write, e.rw);
          check("mem_read", mem_read, e.mr);
          check("mem_write", mem_write, e.mw);
          check("halt", halt, e.hlt);
          if (e.rw) begin
            check("write_register", write_register, e.wreg);
            check("write_data", write_data, e.wdata);
          end
          if (e.mr || e.mw) check("mem_address", mem_address, e.addr);
          if (e.mw) check("mem_data_in", mem_data_in, e.din);
          if (e.mr) check("mem_data_out", mem_data_out, e.dout);
        end
      end
    end
  end

  // Driver: each run resets for a random length, then runs to halt plus a
  // freeze window, or is aborted by a mid-run reset at a random cycle.
  initial begin
    addInstr(K_LLI, 3, 0, 0, 'h05);
    addInstr(K_LLI, 1, 0, 0, 'h10);
    addInstr(K_LLI, 2, 0, 0, 'h12);
    addInstr(K_NOP, 0, 0, 0, 0);
    addInstr(K_NOP, 0, 0, 0, 0);
    addInstr(K_SLBI, 2, 0, 0, 'h34);
    addInstr(K_NOP, 0, 0, 0, 0);
    addInstr(K_NOP, 0, 0, 0, 0);
    addInstr(K_ST, 0, 1, 2, 0);
    addInstr(K_LD, 4, 1, 0, 0);
    addInstr(K_NOP, 0, 0, 0, 0);
    addInstr(K_NOP, 0, 0, 0, 0);
    addInstr(K_ADD, 5, 3, 4, 0);
    addInstr(K_HALT, 0, 0, 0, 0);
    buildModel();

    for (int run = 0; run < 6; run++) begin
      int rstLen, runLen;
      bit full;
      rstLen = (run == 0) ? 3 : $urandom_range(1, 4);
      full   = (run == 0 || run == 5) ? 1'b1 : ((run == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1 expQ = runEvents;
      repeat (rstLen - 1) @(posedge clk);
      #1 rst = 1'b0;
      runLen = full ? haltCyc + $urandom_range(10, 20) : $urandom_range(2, haltCyc - 1);
      repeat (runLen) @(posedge clk);
      #1;
      if (full) check("queue_drained_after_halt", expQ.size(), 0);
      rst = 1'b1;
    end
    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/proc_hier_top.md
Name: proc_hier_top

Overview:
- Top-level processor hierarchy wrapper: instantiates the 5-stage pipelined core and exposes a flat architectural trace/statistics interface for simulation checkers.
- Trace outputs:
  - register writeback, taken from MEM/WB;
  - data memory access, taken from EX/MEM;
  - halt.
- Also keeps cycle, instruction and cache-request/hit counters so a bench can print a run summary when halt is reached.

Parameters:
- CNT_W, 32, width of every statistics counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- reg_write  out  1  register file written this cycle (MEM/WB regwrite)
- write_register  out  3  destination register (MEM/WB rd address)
- write_data  out  16  writeback data (MEM/WB write data)
- mem_read  out  1  data memory load this cycle
- mem_write  out  1  data memory store this cycle
- mem_address  out  16  data memory address (EX/MEM ALU result)
- mem_data_in  out  16  store data (EX/MEM rt value)
- mem_data_out  out  16  data returned by data memory
- halt  out  1  halt instruction in writeback (MEM/WB dump flag)
- icache_req, icache_hit, dcache_req, dcache_hit  out  1 each  cache activity strobes
- cycle_count  out  CNT_W  cycles since reset released
- inst_count  out  CNT_W  retired instructions
- icache_req_count, icache_hit_count, dcache_req_count, dcache_hit_count  out  CNT_W each

Behaviour:
- Sub-block "proc" (existing core) provides these outputs:
  - MEM/WB: regwrite, rd address, write data, dmem-dump.
  - EX/MEM: dmem enable, dmem write, ALU result, rt value.
  - Memory stage: read data.
- Trace outputs are purely combinational from proc outputs; zero added latency.
  - mem_read = dmem_en & ~dmem_write.
  - mem_write = dmem_en & dmem_write; both never high together.
- Cache strobes, with no caches present: icache_req=1, dcache_req=1, icache_hit=0, dcache_hit=0.
- Counters, synchronous to clk:
  - While rst=1, all counters and the halted flag clear to 0.
  - Each cycle with rst=0 and halted=0:
    - cycle_count +1.
    - inst_count +1 if halt | reg_write | mem_write (a cycle counts at most once).
    - Each cache counter +1 if its strobe is high.
  - The cycle in which halt=1 is itself counted. halted then sets (sticky) and all counters freeze until rst.
- Counters wrap modulo 2^CNT_W. No saturation.
- rst asserted mid-run clears counters and halted on the next edge; proc is reset by the same rst.
- Trace outputs during rst follow proc's pipeline registers, which reset to 0, so reg_write, mem_read, mem_write and halt are 0 in the cycle after reset.

Optional Feature:
- CACHE_STATS_EN:
  - Defined: the four cache counters are implemented as described.
  - Undefined: the cache counters are tied to 0 and no counter flops are generated.
  - All other outputs are unchanged in both cases.

Decomposition:
- Shared package holds:
  - widths: DATA_W=16, REG_ADDR_W=3;
  - default CNT_W;
  - the stats counter record typedef.
- One natural sub-module, proc_stats: halted flag plus all counters, fed by the strobes. proc_hier_top = proc + proc_stats + combinational trace assigns.

Test Plan:
- Reset: hold rst=1 for 3 cycles → every counter 0; reg_write=mem_read=mem_write=halt=0.
- ALU op writing r3=0x0005 → exactly one cycle with reg_write=1, write_register=3, write_data=0x0005; inst_count increments by 1.
- Store 0x1234 to 0x0010, then load 0x0010:
  - store cycle: mem_write=1, mem_address=0x0010, mem_data_in=0x1234;
  - later load cycle: mem_read=1, mem_data_out=0x1234;
  - both never high in the same cycle.
- Halt after N cycles → halt=1 for one cycle; cycle_count=N includes the halt cycle; counters frozen for 10 further cycles.
- With CACHE_STATS_EN: run 20 cycles → icache_req_count=dcache_req_count=20, hit counts 0. Without it: all four read 0.
- Assert rst mid-run, after halt → counters and halted clear next edge; counting resumes on release.
